// File: rtl/fifo8x8_pkg.sv
// Shared types and constants for the 8x8 byte FIFO.
// count_next captures the occupancy update rule for accepted writes and reads.
package fifo_pkg;

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

    typedef logic [FIFO_AW:0]      count_t;
    typedef logic [FIFO_AW-1:0]    ptr_t;
    typedef logic [FIFO_WIDTH-1:0] data_t;

    function automatic count_t count_next(count_t cnt, logic wr_go, logic rd_go);
        count_t nxt;
        case ({wr_go, rd_go})
            2'b10:   nxt = cnt + count_t'(1'b1);
            2'b01:   nxt = cnt - count_t'(1'b1);
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fifo8x8_if.sv
// Producer/consumer handshake and status bundle of the byte FIFO.
interface fifo8x8_if;
    import fifo_pkg::*;

    logic   wren;
    logic   rden;
    data_t  DataIn;
    data_t  DataOut;
    logic   data_out_valid;
    logic   fifo_full;
    logic   fifo_empty;
    count_t fifo_count;
    logic   wr_overflow;
    logic   rd_underflow;

    modport master (
        output wren, rden, DataIn,
        input  DataOut, data_out_valid, fifo_full, fifo_empty,
               fifo_count, wr_overflow, rd_underflow
    );

    modport slave (
        input  wren, rden, DataIn,
        output DataOut, data_out_valid, fifo_full, fifo_empty,
               fifo_count, wr_overflow, rd_underflow
    );
endinterface

// File: rtl/fifo8x8_mem.sv
// DEPTH x WIDTH register file: synchronous write, registered read port.
// The array itself is never reset; only the read register is.
module fifo8x8_mem
    import fifo_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_en_i,
    input  ptr_t  wr_addr_i,
    input  data_t wr_data_i,
    input  logic  rd_en_i,
    input  ptr_t  rd_addr_i,
    output data_t rd_data_o
);

    data_t mem_q [FIFO_DEPTH];
    data_t rd_data_q;

    // Storage array write port
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register, holds its value between reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= data_t'(8'h00);
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo8x8.sv
// Single-clock 8-entry byte FIFO with registered status flags and error pulses.
// Full/empty are derived from the occupancy counter, not from pointer compare.
module fifo8x8
    import fifo_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    fifo8x8_if.slave bus
);

    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   rd_ptr_q, rd_ptr_d;
    count_t count_q,  count_d;
    logic   full_q,   full_d;
    logic   empty_q,  empty_d;
    logic   valid_q,  valid_d;
    logic   ovf_q,    ovf_d;
    logic   udf_q,    udf_d;
    logic   wr_go_s;
    logic   rd_go_s;

    // Acceptance decisions and next-state for pointers, count and flags
    always_comb begin
        wr_go_s  = bus.wren & ~full_q;
        rd_go_s  = bus.rden & ~empty_q;
        if (wr_go_s) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_go_s) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_next(count_q, wr_go_s, rd_go_s);
        full_d  = (count_d == count_t'(FIFO_DEPTH));
        empty_d = (count_d == count_t'(1'b0));
        valid_d = rd_go_s;
        ovf_d   = bus.wren & full_q;
        udf_d   = bus.rden & empty_q;
    end

    // Control state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= ptr_t'(1'b0);
            rd_ptr_q <= ptr_t'(1'b0);
            count_q  <= count_t'(1'b0);
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo8x8_mem u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_go_s),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (bus.DataIn),
        .rd_en_i   (rd_go_s),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (bus.DataOut)
    );

    assign bus.data_out_valid = valid_q;
    assign bus.fifo_full      = full_q;
    assign bus.fifo_empty     = empty_q;
    assign bus.fifo_count     = count_q;
    assign bus.wr_overflow    = ovf_q;
    assign bus.rd_underflow   = udf_q;

endmodule

// File: tb/tb_fifo8x8.sv
// Self-checking bench for fifo8x8: directed test-plan sequences plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_fifo8x8;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fifo8x8_if bus();

    fifo8x8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    data_t m_q[$];
    data_t m_dout;
    bit    m_valid;
    bit    m_ovf;
    bit    m_udf;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dout  = 8'h00;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    task automatic check_all(input string ctx);
        check_eq({ctx, ".count"}, 32'(bus.fifo_count), 32'(m_q.size()));
        check_eq({ctx, ".full"},  32'(bus.fifo_full),  32'(m_q.size() == FIFO_DEPTH));
        check_eq({ctx, ".empty"}, 32'(bus.fifo_empty), 32'(m_q.size() == 0));
        check_eq({ctx, ".dout"},  32'(bus.DataOut),    32'(m_dout));
        check_eq({ctx, ".valid"}, 32'(bus.data_out_valid), 32'(m_valid));
        check_eq({ctx, ".ovf"},   32'(bus.wr_overflow),    32'(m_ovf));
        check_eq({ctx, ".udf"},   32'(bus.rd_underflow),   32'(m_udf));
    endtask

    // One clock cycle: drive, let the edge happen, update the model, compare.
    task automatic step(input string ctx, input bit w, input bit r, input data_t d);
        int occ;
        bus.wren   = w;
        bus.rden   = r;
        bus.DataIn = d;
        @(posedge clk);
        occ     = m_q.size();
        m_ovf   = w && (occ == FIFO_DEPTH);
        m_udf   = r && (occ == 0);
        m_valid = r && (occ > 0);
        if (m_valid) m_dout = m_q.pop_front();
        if (w && occ < FIFO_DEPTH) m_q.push_back(d);
        #1;
        check_all(ctx);
    endtask

    // Asynchronous reset pulse asserted between clock edges.
    task automatic async_reset(input string ctx);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all(ctx);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bus.wren   = 1'b0;
        bus.rden   = 1'b0;
        bus.DataIn = 8'h00;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("por");
        @(negedge clk);
        rst = 1'b1;

        step("idle", 1'b0, 1'b0, 8'h00);
        step("idle", 1'b0, 1'b0, 8'h00);
        async_reset("rst_idle");

        for (int i = 1; i <= 16; i++) step("fill", 1'b1, 1'b0, data_t'(i));
        check_eq("fill.count8", 32'(bus.fifo_count), 32'd8);
        for (int i = 0; i < 16; i++) step("drain", 1'b0, 1'b1, 8'h00);
        check_eq("drain.hold08", 32'(bus.DataOut), 32'h08);

        for (int i = 0; i < 5; i++) step("wrap_w5", 1'b1, 1'b0, data_t'($urandom));
        for (int i = 0; i < 5; i++) step("wrap_r5", 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 8; i++) step("wrap_w8", 1'b1, 1'b0, data_t'(8'hA0 + i));
        check_eq("wrap.full", 32'(bus.fifo_full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step("wrap_r8", 1'b0, 1'b1, 8'h00);
            check_eq("wrap.order", 32'(bus.DataOut), 32'(8'hA0 + i));
        end

        for (int i = 0; i < 3; i++) step("sim_pre", 1'b1, 1'b0, data_t'($urandom));
        for (int i = 0; i < 4; i++) step("sim_rw", 1'b1, 1'b1, data_t'($urandom));
        for (int i = 0; i < 3; i++) step("sim_drain", 1'b0, 1'b1, 8'h00);
        step("sim_at0", 1'b1, 1'b1, 8'h5A);
        check_eq("sim_at0.count", 32'(bus.fifo_count), 32'd1);
        for (int i = 0; i < 7; i++) step("sim_fill", 1'b1, 1'b0, data_t'($urandom));
        step("sim_at8", 1'b1, 1'b1, 8'hC3);
        check_eq("sim_at8.count", 32'(bus.fifo_count), 32'd7);

        while (m_q.size() > 0) step("pre_burst", 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) step("burst", 1'b1, 1'b0, data_t'($urandom));
        async_reset("rst_burst");

        for (int phase = 0; phase < 4; phase++) begin
            int wp;
            int rp;
            wp = (phase == 0) ? 80 : (phase == 1) ? 30 : 55;
            rp = (phase == 0) ? 30 : (phase == 1) ? 80 : 55;
            for (int i = 0; i < 150; i++) begin
                step("rand", ($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp),
                     data_t'($urandom));
            end
            if (phase == 2) async_reset("rst_rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
